// File: rtl/jellyvl_etherneco_pkg.sv
// Shared types for the etherneco ring TX path: scheduler FSM state codes and default length type.
package jellyvl_etherneco_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_START  = 2'd1;
   localparam state_t ST_STREAM = 2'd2;
   localparam state_t ST_GAP    = 2'd3;

   localparam int DEFAULT_LEN_WIDTH = 16;
   typedef logic [DEFAULT_LEN_WIDTH-1:0] length_t;

endpackage

// File: rtl/jellyvl_etherneco_next_src.sv
// Combinational finder: lowest set mask bit strictly above base, or lowest set bit overall when from_start.
module jellyvl_etherneco_next_src #(
   parameter int NUM_SRC   = 2,
   parameter int IDX_WIDTH = 1
)(
   input  logic [NUM_SRC-1:0]   mask,
   input  logic                 from_start,
   input  logic [IDX_WIDTH-1:0] base,
   output logic                 found,
   output logic [IDX_WIDTH-1:0] idx
);

   // Scan downward so the lowest qualifying index is the one left standing.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (mask[i] && (from_start || (i > int'(base)))) begin
            found = 1'b1;
            idx   = IDX_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/jellyvl_etherneco_tx_scheduler.sv
// Per-period TX sequencer: grants the framer to each enabled source in index order, one packet each.
// Statistics counters exist only when JELLYVL_ETHERNECO_TX_SCHEDULER_STATS_EN is defined.
module jellyvl_etherneco_tx_scheduler
   import jellyvl_etherneco_pkg::*;
#(
   parameter int  NUM_SRC        = 2,
   parameter int  LEN_WIDTH      = 16,
   parameter int  GAP_CYCLES     = 16,
   parameter int  TIMEOUT_CYCLES = 4096,
   localparam int IDX_WIDTH      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
)(
   input  logic                         reset,
   input  logic                         clk,
   input  logic                         trigger,
   input  logic [NUM_SRC-1:0]           src_enable,
   input  logic [NUM_SRC*LEN_WIDTH-1:0] src_length,
   output logic [NUM_SRC-1:0]           src_start,
   input  logic [NUM_SRC-1:0]           s_last,
   input  logic [NUM_SRC*8-1:0]         s_data,
   input  logic [NUM_SRC-1:0]           s_valid,
   output logic [NUM_SRC-1:0]           s_ready,
   output logic                         tx_start,
   output logic [LEN_WIDTH-1:0]         tx_length,
   output logic                         tx_cancel,
   output logic                         m_last,
   output logic [7:0]                   m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         busy,
   output logic                         overrun,
   output logic [IDX_WIDTH-1:0]         cur_src,
   output logic [31:0]                  pkt_count,
   output logic [15:0]                  overrun_count
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   state_t                       state;
   logic [NUM_SRC-1:0]           mask_q;
   logic [NUM_SRC-1:0]           mask_new;
   logic [NUM_SRC*LEN_WIDTH-1:0] len_q;
   logic [GAP_W-1:0]             gap_cnt;
   logic [TO_W-1:0]              to_cnt;
   logic                         nxt_found;
   logic [IDX_WIDTH-1:0]         nxt_idx;
   logic                         timeout;
   logic                         hs;
   logic                         hs_last;

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         mask_new[i] = src_enable[i] && (src_length[i*LEN_WIDTH +: LEN_WIDTH] != '0);
      end
   end

   // In IDLE the search runs on the live inputs so the trigger cycle itself can grant.
   jellyvl_etherneco_next_src #(
      .NUM_SRC   (NUM_SRC),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_next_src (
      .mask       ((state == ST_IDLE) ? mask_new : mask_q),
      .from_start (state == ST_IDLE),
      .base       (cur_src),
      .found      (nxt_found),
      .idx        (nxt_idx)
   );

   assign timeout   = (state == ST_STREAM) && (to_cnt == TO_LAST);
   assign tx_start  = (state == ST_START);
   assign tx_cancel = timeout;
   assign busy      = (state != ST_IDLE);
   assign overrun   = trigger && (state != ST_IDLE);
   assign hs        = m_valid && m_ready;
   assign hs_last   = hs && m_last;

   // Zero-latency payload path; the cancel cycle blocks any handshake on either side.
   always_comb begin
      src_start = '0;
      s_ready   = '0;
      m_last    = 1'b0;
      m_data    = 8'd0;
      m_valid   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cur_src == IDX_WIDTH'(i)) begin
            src_start[i] = (state == ST_START);
            if (state == ST_STREAM) begin
               m_last     = s_last[i];
               m_data     = s_data[i*8 +: 8];
               m_valid    = s_valid[i] && !timeout;
               s_ready[i] = m_ready && !timeout;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cur_src   <= '0;
         tx_length <= '0;
         mask_q    <= '0;
         len_q     <= '0;
         gap_cnt   <= '0;
         to_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  mask_q <= mask_new;
                  len_q  <= src_length;
                  if (nxt_found) begin
                     cur_src <= nxt_idx;
                     for (int i = 0; i < NUM_SRC; i++) begin
                        if (nxt_idx == IDX_WIDTH'(i)) tx_length <= src_length[i*LEN_WIDTH +: LEN_WIDTH];
                     end
                     state <= ST_START;
                  end
               end
            end
            ST_START: begin
               to_cnt <= '0;
               state  <= ST_STREAM;
            end
            ST_STREAM: begin
               if (hs_last || timeout) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP;
               end else if (hs) begin
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            default: begin
               if (gap_cnt == '0) begin
                  if (nxt_found) begin
                     cur_src <= nxt_idx;
                     for (int i = 0; i < NUM_SRC; i++) begin
                        if (nxt_idx == IDX_WIDTH'(i)) tx_length <= len_q[i*LEN_WIDTH +: LEN_WIDTH];
                     end
                     state <= ST_START;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
         endcase
      end
   end

`ifdef JELLYVL_ETHERNECO_TX_SCHEDULER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count     <= '0;
         overrun_count <= '0;
      end else begin
         if (hs_last) pkt_count <= pkt_count + 32'd1;
         if (overrun && (overrun_count != 16'hFFFF)) overrun_count <= overrun_count + 16'd1;
      end
   end
`else
   assign pkt_count     = '0;
   assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_jellyvl_etherneco_tx_scheduler.sv
// Randomized scoreboard bench for jellyvl_etherneco_tx_scheduler (NUM_SRC=2, short gap/timeout).
module tb_jellyvl_etherneco_tx_scheduler;

   localparam int NS      = 2;
   localparam int LW      = 16;
   localparam int GAP     = 6;
   localparam int TIMEOUT = 64;
   localparam int BOUND   = 4 * TIMEOUT + 400;

   logic              reset, clk, trigger, m_ready;
   logic [NS-1:0]     src_enable, src_start, s_last, s_valid, s_ready;
   logic [NS*LW-1:0]  src_length;
   logic [NS*8-1:0]   s_data;
   logic              tx_start, tx_cancel, m_last, m_valid, busy, overrun;
   logic [LW-1:0]     tx_length;
   logic [7:0]        m_data;
   logic [0:0]        cur_src;
   logic [31:0]       pkt_count;
   logic [15:0]       overrun_count;

   jellyvl_etherneco_tx_scheduler #(
      .NUM_SRC(NS), .LEN_WIDTH(LW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .reset(reset), .clk(clk), .trigger(trigger),
      .src_enable(src_enable), .src_length(src_length), .src_start(src_start),
      .s_last(s_last), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .tx_start(tx_start), .tx_length(tx_length), .tx_cancel(tx_cancel),
      .m_last(m_last), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .overrun(overrun), .cur_src(cur_src),
      .pkt_count(pkt_count), .overrun_count(overrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input longint a, input longint e);
      n_cmp++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   // One expected grant: which source, what length, its payload seed, and whether it must time out.
   typedef struct {
      int     src;
      int     len;
      int     base;
      bit     cancel;
      bit     first;
      longint trig_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   exp_pkt = 0;
   int   exp_ovr = 0;

   // Source behaviour configuration for the current period.
   int          len_cfg  [NS];
   int          base_cfg [NS];
   logic [NS-1:0] stall_cfg = '0;
   int          ready_mode = 0;

   function automatic logic [7:0] pay_byte(input int base, input int idx);
      return 8'(base + idx * 13);
   endfunction

   // Payload sources and framer ready: sample at negedge, drive just after posedge.
   bit dr_hs [NS];
   bit dr_st [NS];
   bit dr_rst, dr_cancel;
   int dr_cur;
   int s_idx [NS];
   bit s_act [NS];

   always begin
      @(negedge clk);
      dr_rst    = reset;
      dr_cancel = tx_cancel;
      dr_cur    = int'(cur_src);
      for (int i = 0; i < NS; i++) begin
         dr_hs[i] = s_valid[i] && s_ready[i];
         dr_st[i] = src_start[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (dr_rst) begin
            s_act[i] = 1'b0;
         end else begin
            if (dr_hs[i]) begin
               s_idx[i]++;
               if (s_idx[i] >= len_cfg[i]) s_act[i] = 1'b0;
            end
            if (dr_cancel && dr_cur == i) s_act[i] = 1'b0;
            if (dr_st[i]) begin
               s_act[i] = 1'b1;
               s_idx[i] = 0;
            end
         end
         s_valid[i]       = s_act[i] && !stall_cfg[i] && ($urandom_range(0, 3) != 0);
         s_data[i*8 +: 8] = pay_byte(base_cfg[i], s_idx[i]);
         s_last[i]        = (s_idx[i] == len_cfg[i] - 1);
      end
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = !m_ready;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pops an expected grant on every tx_start and checks the stream against it.
   exp_t   cur;
   bit     act = 1'b0;
   int     cur_idx = 0;
   longint start_cyc = 0;
   longint end_cyc = 0;
   int     exp_txlen = 0;

   always @(negedge clk) begin
      bit          in_stream, cxl, ev;
      logic [NS-1:0] er;
      if (reset) begin
         act       = 1'b0;
         exp_txlen = 0;
      end else begin
         in_stream = act && (cyc > start_cyc);
         cxl       = in_stream && cur.cancel && (cyc == start_cyc + TIMEOUT);
         er = '0;
         ev = 1'b0;
         if (in_stream && !cxl) begin
            er[cur.src] = m_ready;
            ev          = s_valid[cur.src];
         end
         chk("s_ready", s_ready, er);
         chk("m_valid", m_valid, ev);
         chk("tx_cancel", tx_cancel, cxl);
         chk("overrun_without_trigger", overrun & ~trigger, 0);
         if (in_stream && m_valid && m_ready) begin
            chk("m_data", m_data, pay_byte(cur.base, cur_idx));
            chk("m_last", m_last, cur_idx == cur.len - 1);
            cur_idx++;
            if (m_last) begin
               act     = 1'b0;
               end_cyc = cyc;
            end
         end
         if (cxl) begin
            act     = 1'b0;
            end_cyc = cyc;
         end
         if (tx_start) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_start: tx_start=1 at cycle %0d, required no start", cyc);
            end else begin
               cur = exp_q.pop_front();
               if (cur.first) chk("start_latency", cyc, cur.trig_cyc + 1);
               else           chk("gap_latency", cyc, end_cyc + GAP + 1);
               chk("src_start", src_start, 1 << cur.src);
               chk("cur_src", cur_src, cur.src);
               exp_txlen = cur.len;
               act       = 1'b1;
               start_cyc = cyc;
               cur_idx   = 0;
            end
         end else begin
            chk("src_start_idle", src_start, 0);
         end
         chk("tx_length", tx_length, exp_txlen);
      end
   end

   // Reference model: every enabled source with nonzero length gets one grant, in index order.
   task automatic start_period(input logic [1:0] en, input int l0, input int l1,
                               input logic [1:0] st, input int rm, output int granted);
      int lens [NS];
      lens[0]    = l0;
      lens[1]    = l1;
      src_enable = en;
      src_length = {16'(l1), 16'(l0)};
      stall_cfg  = st;
      ready_mode = rm;
      granted    = 0;
      for (int i = 0; i < NS; i++) begin
         exp_t e;
         len_cfg[i]  = lens[i];
         base_cfg[i] = $urandom_range(0, 255);
         if (en[i] && lens[i] != 0) begin
            e.src      = i;
            e.len      = lens[i];
            e.base     = base_cfg[i];
            e.cancel   = st[i];
            e.first    = (granted == 0);
            e.trig_cyc = cyc;
            exp_q.push_back(e);
            granted++;
            if (!st[i]) exp_pkt++;
         end
      end
      trigger = 1'b1;
      @(negedge clk);
      chk("overrun_on_idle_trigger", overrun, 0);
      @(posedge clk);
      #1;
      trigger = 1'b0;
      // Mid-period input changes must not disturb the latched grant set.
      src_enable = 2'($urandom);
      src_length = {16'($urandom), 16'($urandom)};
   endtask

   task automatic finish_period();
      int w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (busy && w < BOUND);
      chk("period_end_busy", busy, 0);
      chk("pending_grants", exp_q.size(), 0);
`ifdef JELLYVL_ETHERNECO_TX_SCHEDULER_STATS_EN
      chk("pkt_count", pkt_count, exp_pkt);
      chk("overrun_count", overrun_count, exp_ovr);
`else
      chk("pkt_count_tied", pkt_count, 0);
      chk("overrun_count_tied", overrun_count, 0);
`endif
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_period(input logic [1:0] en, input int l0, input int l1,
                             input logic [1:0] st, input int rm, input bit early);
      int g;
      start_period(en, l0, l1, st, rm, g);
      if (early && g > 0) begin
         repeat (4) @(posedge clk);
         #1;
         trigger = 1'b1;
         @(negedge clk);
         chk("overrun_while_busy", overrun, 1);
         exp_ovr++;
         @(posedge clk);
         #1;
         trigger = 1'b0;
      end
      finish_period();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      logic [1:0] en, st;
      int l0, l1;
      reset      = 1'b1;
      trigger    = 1'b0;
      m_ready    = 1'b1;
      src_enable = '0;
      src_length = '0;
      s_valid    = '0;
      s_last     = '0;
      s_data     = '0;
      for (int i = 0; i < NS; i++) begin
         len_cfg[i]  = 0;
         base_cfg[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_length", tx_length, 0);
      chk("rst_tx_cancel", tx_cancel, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_src_start", src_start, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_cur_src", cur_src, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_overrun_count", overrun_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run_period(2'b11, 11, 4, 2'b00, 0, 1'b0);
      run_period(2'b10, 5, 7, 2'b00, 0, 1'b0);
      run_period(2'b11, 0, 6, 2'b00, 2, 1'b0);
      run_period(2'b11, 9, 8, 2'b00, 1, 1'b0);
      run_period(2'b11, 5, 3, 2'b01, 0, 1'b0);
      run_period(2'b11, 6, 6, 2'b00, 0, 1'b1);
      run_period(2'b00, 6, 6, 2'b00, 0, 1'b0);
      run_period(2'b01, 1, 0, 2'b00, 0, 1'b0);

      for (int k = 0; k < 16; k++) begin
         en = 2'($urandom_range(0, 3));
         l0 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
         l1 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
         st = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_period(en, l0, l1, st, int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
      end

      // Reset in the middle of source 0's packet, then a clean period.
      start_period(2'b11, 30, 30, 2'b00, 0, g);
      repeat (8) @(posedge clk);
      #1;
      exp_q.delete();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_tx_start", tx_start, 0);
      chk("midrst_tx_length", tx_length, 0);
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_s_ready", s_ready, 0);
      chk("midrst_src_start", src_start, 0);
      chk("midrst_tx_cancel", tx_cancel, 0);
      chk("midrst_cur_src", cur_src, 0);
      chk("midrst_pkt_count", pkt_count, 0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      exp_pkt = 0;
      exp_ovr = 0;
      repeat (2) @(posedge clk);
      #1;
      run_period(2'b11, 3, 2, 2'b00, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/jellyvl_etherneco_tx_scheduler.md
Name: jellyvl_etherneco_tx_scheduler

Overview:
Per-period sequencer and arbiter for the ring inner TX framer (jellyvl_etherneco_tx).
- On each period trigger, grants the framer to up to NUM_SRC packet sources in fixed index order, one packet each.
- Issues tx_start/tx_length, muxes the granted source's payload stream, enforces an inter-packet gap, and cancels stuck packets.
- Sits between jellyvl_periodic_trigger, the payload generators (synctimer master, register-access master, ...) and the framer.

Parameters:
NUM_SRC, 2, number of payload sources; index 0 has highest order.
LEN_WIDTH, 16, width of packet length fields.
GAP_CYCLES, 16, idle cycles between end of one packet and the next start; must be >= 1.
TIMEOUT_CYCLES, 4096, maximum STREAM cycles without a payload handshake before cancel.

Ports:
reset  in  1  synchronous, active-high reset
clk  in  1  clock
trigger  in  1  period start pulse
src_enable  in  NUM_SRC  per-source enable; sampled at trigger
src_length  in  NUM_SRC*LEN_WIDTH  per-source packet length; sampled at trigger
src_start  out  NUM_SRC  one-hot start pulse to the granted source
s_last  in  NUM_SRC  source payload last
s_data  in  NUM_SRC*8  source payload data
s_valid  in  NUM_SRC  source payload valid
s_ready  out  NUM_SRC  source payload ready; only the granted bit can be 1
tx_start  out  1  framer start pulse
tx_length  out  LEN_WIDTH  framer length; held stable from START until the next START
tx_cancel  out  1  framer cancel pulse
m_last  out  1  payload to framer
m_data  out  8  payload to framer
m_valid  out  1  payload to framer
m_ready  in  1  payload from framer
busy  out  1  state != IDLE
overrun  out  1  pulse: trigger arrived while busy
cur_src  out  $clog2(NUM_SRC) (min 1)  granted index
pkt_count  out  32  statistics; see Optional Feature
overrun_count  out  16  statistics; see Optional Feature

Behaviour:
- Reset values: state IDLE, every output 0, latched mask 0.
- Reset mid-operation aborts immediately. No cancel is issued. The framer is reset by the same reset.
- Latched mask: bit i = src_enable[i] && src_length[i] != 0, captured with src_length on the trigger accepted in IDLE. Zero-length sources are skipped.
- FSM:
  - IDLE: on trigger, pick the lowest set mask bit. If none, stay IDLE with no output activity. Otherwise cur_src = that index, go START.
  - START: exactly one cycle. tx_start=1, src_start[cur_src]=1, tx_length = latched length. Go STREAM.
  - STREAM:
    - m_* = s_*[cur_src]; s_ready[cur_src] = m_ready; all other s_ready are 0. Path is combinational, zero latency.
    - On m_valid && m_ready && m_last: go GAP, gap counter = GAP_CYCLES-1.
    - Timeout counter clears on every handshake and on entry. When it reaches TIMEOUT_CYCLES-1: pulse tx_cancel for 1 cycle, force s_ready to 0, go GAP.
  - GAP: counter decrements each cycle. At 0, pick the lowest mask bit with index > cur_src. If found go START, else go IDLE.
- Latency:
  - trigger at cycle T gives tx_start at T+1.
  - A last handshake at cycle L gives the next tx_start at L+GAP_CYCLES+1.
- m_valid=0 outside STREAM.
- Trigger when state != IDLE: ignored; overrun=1 for that cycle. A trigger in the same cycle the FSM returns to IDLE is also an overrun.
- src_enable/src_length changes mid-period have no effect until the next accepted trigger.

Optional Feature:
JELLYVL_ETHERNECO_TX_SCHEDULER_STATS_EN
- Defined:
  - pkt_count increments on each completed (non-cancelled) last handshake and wraps at 2^32.
  - overrun_count increments on each overrun pulse and saturates at 16'hFFFF.
  - Both counters clear on reset.
- Undefined: both ports are tied to 0 and no counters are synthesized.

Decomposition:
- Package jellyvl_etherneco_pkg holds:
  - state enum type (IDLE, START, STREAM, GAP);
  - length typedef for the LEN_WIDTH=16 default.
- Sub-module jellyvl_etherneco_next_src: combinational "lowest set bit above index" finder. Used in IDLE (base -1) and GAP.

Test Plan:
- NUM_SRC=2, both enabled, lengths 11 and 4, trigger at T, m_ready=1 -> tx_start at T+1 with tx_length=11. Source 0 payload passes through. The second tx_start arrives GAP_CYCLES+1 after the first last handshake, with tx_length=4. Then IDLE; busy drops.
- src_enable=2'b10 (or src_length[0]=0) -> only source 1 granted; src_start=2'b10; s_ready[0] stays 0 throughout.
- m_ready toggling 1/0 every cycle during STREAM -> m_* matches the granted source byte-for-byte; no data loss or duplication.
- Source 0 stalls with s_valid=0 for TIMEOUT_CYCLES -> one tx_cancel pulse. Source 1 still starts after the gap. pkt_count +1 only (with STATS_EN).
- Second trigger 5 cycles after the first -> overrun pulse. Sequence unaffected; overrun_count=1 (with STATS_EN).
- Reset asserted mid-STREAM -> next cycle all outputs 0, state IDLE. A following trigger starts normally.
